// File: rtl/scoreboard_regfile.sv
// Register file with a per-register pending-write scoreboard, same-cycle writeback bypass
// and decode stall generation. Writebacks retire in issue order per register.
module scoreboard_regfile #(
  parameter int DBITS    = 16,
  parameter int ABITS    = 3,
  parameter int NRD      = 2,
  parameter int MAXPEND  = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [NRD*ABITS-1:0]  RADDR,
  input  logic [NRD-1:0]        RREQ,
  output logic [NRD*DBITS-1:0]  RDATA,
  input  logic                  ISS_VALID,
  input  logic                  ISS_WE,
  input  logic [ABITS-1:0]      ISS_WADDR,
  output logic                  ISS_ACK,
  output logic                  STALL,
  input  logic                  WB_WE,
  input  logic [ABITS-1:0]      WB_WADDR,
  input  logic [DBITS-1:0]      WB_DATA,
  input  logic                  FLUSH,
  output logic [2**ABITS-1:0]   BUSY
);

  localparam int NREG = 2**ABITS;
  localparam int CW   = $clog2(MAXPEND + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXPEND);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [DBITS-1:0] regs_q [NREG];
  logic [DBITS-1:0] regs_d [NREG];
  logic [CW-1:0]    cnt_q  [NREG];
  logic [CW-1:0]    cnt_d  [NREG];

  logic [ABITS-1:0] ra [NRD];
  logic [NRD-1:0]   hazard;
  logic             overflow;
  logic             offered;
  logic             blocked;
  logic             wb_en;

  // Register 0 is hardwired when ZERO_REG is set, so its writes are dropped.
  assign wb_en = WB_WE && !(ZERO_REG != 0 && WB_WADDR == '0);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    hazard = '0;
    RDATA  = '0;
    for (int i = 0; i < NRD; i++) begin
      ra[i] = RADDR[i*ABITS +: ABITS];
      if (ZERO_REG != 0 && ra[i] == '0)
        RDATA[i*DBITS +: DBITS] = '0;
      else if (WB_WE && WB_WADDR == ra[i])
        RDATA[i*DBITS +: DBITS] = WB_DATA;
      else
        RDATA[i*DBITS +: DBITS] = regs_q[ra[i]];
      // Only the newest pending write may be bypassed; with cnt>1 an older one is retiring.
      hazard[i] = RREQ[i] && (cnt_q[ra[i]] != '0) &&
                  !(WB_WE && WB_WADDR == ra[i] && cnt_q[ra[i]] == CNT_ONE);
    end
    if (!RESETN) RDATA = '0;
  end

  always_comb begin
    overflow = ISS_WE && (cnt_q[ISS_WADDR] == CNT_MAX) &&
               !(WB_WE && WB_WADDR == ISS_WADDR);
    offered  = RESETN && ISS_VALID && !FLUSH;
    blocked  = (|hazard) || overflow;
    STALL    = offered && blocked;
    ISS_ACK  = offered && !blocked;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc;
      logic dec;
      inc = ISS_ACK && ISS_WE && ISS_WADDR == ABITS'(r) && !(ZERO_REG != 0 && r == 0);
      dec = WB_WE && WB_WADDR == ABITS'(r) && cnt_q[r] != '0;
      regs_d[r] = (wb_en && WB_WADDR == ABITS'(r)) ? WB_DATA : regs_q[r];
      cnt_d[r]  = cnt_q[r];
      if (FLUSH)
        cnt_d[r] = '0;
      else if (inc && !dec)
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec && !inc)
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      BUSY[r] = (cnt_q[r] != '0);
    end
  end

  // NOTE: the data array is reset along with the counters because a reset must read back as zero.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Scoreboard bench for scoreboard_regfile: the driver pushes expectations from an
// in-flight-list model; a monitor pops and compares them against the DUT every cycle.
module tb_scoreboard_regfile;

  localparam int DBITS = 16, ABITS = 3, NRD = 2, MAXPEND = 3, ZERO_REG = 1;
  localparam int NREG = 2**ABITS;

  typedef struct {
    logic                 stall;
    logic                 ack;
    logic [NRD*DBITS-1:0] rdata;
    logic [NREG-1:0]      busy;
  } exp_t;

  logic                 CLK = 0;
  logic                 RESETN = 0;
  logic [NRD*ABITS-1:0] RADDR = '0;
  logic [NRD-1:0]       RREQ = '0;
  logic [NRD*DBITS-1:0] RDATA;
  logic                 ISS_VALID = 0, ISS_WE = 0;
  logic [ABITS-1:0]     ISS_WADDR = '0;
  logic                 ISS_ACK, STALL;
  logic                 WB_WE = 0;
  logic [ABITS-1:0]     WB_WADDR = '0;
  logic [DBITS-1:0]     WB_DATA = '0;
  logic                 FLUSH = 0;
  logic [NREG-1:0]      BUSY;

  scoreboard_regfile #(.DBITS(DBITS), .ABITS(ABITS), .NRD(NRD), .MAXPEND(MAXPEND),
                       .ZERO_REG(ZERO_REG)) dut (
    .CLK(CLK), .RESETN(RESETN), .RADDR(RADDR), .RREQ(RREQ), .RDATA(RDATA),
    .ISS_VALID(ISS_VALID), .ISS_WE(ISS_WE), .ISS_WADDR(ISS_WADDR), .ISS_ACK(ISS_ACK),
    .STALL(STALL), .WB_WE(WB_WE), .WB_WADDR(WB_WADDR), .WB_DATA(WB_DATA),
    .FLUSH(FLUSH), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  // Reference model: architectural values plus the list of issued, not yet retired writes.
  logic [DBITS-1:0] m_regs [NREG];
  int               inflight[$];

  function automatic int pend(input int a);
    int n = 0;
    foreach (inflight[k]) if (inflight[k] == a) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    foreach (m_regs[r]) m_regs[r] = '0;
    inflight.delete();
  endtask

  task automatic step(input logic v, input logic we, input int wa,
                      input int ra0, input int ra1, input logic [1:0] rq,
                      input logic wbwe, input int wba, input logic [DBITS-1:0] wbd,
                      input logic fl);
    exp_t e;
    bit hz, ov, hit;
    int ra[2];
    @(negedge CLK);
    ISS_VALID = v; ISS_WE = we; ISS_WADDR = wa[ABITS-1:0];
    RADDR = {ra1[ABITS-1:0], ra0[ABITS-1:0]}; RREQ = rq;
    WB_WE = wbwe; WB_WADDR = wba[ABITS-1:0]; WB_DATA = wbd; FLUSH = fl;
    #1;
    ra[0] = ra0; ra[1] = ra1; hz = 0;
    for (int i = 0; i < NRD; i++) begin
      hit = wbwe && wba == ra[i];
      if (ZERO_REG != 0 && ra[i] == 0) e.rdata[i*DBITS +: DBITS] = '0;
      else if (hit)                    e.rdata[i*DBITS +: DBITS] = wbd;
      else                             e.rdata[i*DBITS +: DBITS] = m_regs[ra[i]];
      if (rq[i] && pend(ra[i]) > 0 && !(hit && pend(ra[i]) == 1)) hz = 1;
    end
    ov = we && pend(wa) >= MAXPEND && !(wbwe && wba == wa);
    for (int r = 0; r < NREG; r++) e.busy[r] = pend(r) > 0;
    e.stall = v && !fl && (hz || ov);
    e.ack   = v && !fl && !(hz || ov);
    exp_q.push_back(e);
    if (wbwe && !(ZERO_REG != 0 && wba == 0)) m_regs[wba] = wbd;
    if (fl) inflight.delete();
    else begin
      if (wbwe) begin
        foreach (inflight[k]) if (inflight[k] == wba) begin
          inflight.delete(k);
          break;
        end
      end
      if (e.ack && we && !(ZERO_REG != 0 && wa == 0)) inflight.push_back(wa);
    end
  endtask

  task automatic idle(input int ra0, input int ra1, input logic [1:0] rq);
    step(0, 0, 0, ra0, ra1, rq, 0, 0, '0, 0);
  endtask

  // Monitor: compares the DUT against whatever expectation the driver left for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", 64'(STALL), 64'(e.stall));
        check("ack", 64'(ISS_ACK), 64'(e.ack));
        check("busy", 64'(BUSY), 64'(e.busy));
        check("rdata0", 64'(RDATA[0 +: DBITS]), 64'(e.rdata[0 +: DBITS]));
        check("rdata1", 64'(RDATA[DBITS +: DBITS]), 64'(e.rdata[DBITS +: DBITS]));
      end
    end
  end

  initial begin
    model_clear();
    #12 RESETN = 1;

    // Reset contents
    idle(1, 2, 2'b11); idle(3, 4, 2'b11); idle(5, 6, 2'b11); idle(7, 1, 2'b11);

    // Read-after-write hazard resolved by a same-cycle writeback
    step(1, 1, 3, 0, 0, 2'b00, 0, 0, '0, 0);
    step(1, 0, 0, 3, 0, 2'b01, 0, 0, '0, 0);
    step(1, 0, 0, 3, 0, 2'b01, 1, 3, 16'h1234, 0);

    // Pending-count saturation on r2
    repeat (3) step(1, 1, 2, 0, 0, 2'b00, 0, 0, '0, 0);
    step(1, 1, 2, 0, 0, 2'b00, 0, 0, '0, 0);
    step(1, 1, 2, 0, 0, 2'b00, 1, 2, 16'h0002, 0);
    repeat (3) step(0, 0, 0, 2, 0, 2'b01, 1, 2, 16'h0022, 0);
    idle(2, 0, 2'b01);

    // Two pending writes to r5: only the second writeback may be bypassed
    repeat (2) step(1, 1, 5, 0, 0, 2'b00, 0, 0, '0, 0);
    step(1, 0, 0, 0, 5, 2'b10, 1, 5, 16'hAAAA, 0);
    step(1, 0, 0, 0, 5, 2'b10, 1, 5, 16'hBBBB, 0);

    // Hardwired r0
    step(1, 1, 0, 0, 0, 2'b11, 0, 0, '0, 0);
    step(1, 0, 0, 0, 0, 2'b11, 1, 0, 16'hFFFF, 0);
    idle(0, 0, 2'b11);

    // Flush, then a late writeback
    step(1, 1, 4, 0, 0, 2'b00, 0, 0, '0, 0);
    step(1, 1, 6, 0, 0, 2'b00, 0, 0, '0, 0);
    step(0, 0, 0, 4, 6, 2'b11, 0, 0, '0, 1);
    idle(4, 6, 2'b11);
    step(0, 0, 0, 4, 6, 2'b11, 1, 4, 16'h0042, 0);
    idle(4, 6, 2'b11);

    // Asynchronous reset while decode is stalled
    step(1, 1, 7, 0, 0, 2'b00, 0, 0, '0, 0);
    step(1, 0, 0, 7, 3, 2'b11, 0, 0, '0, 0);
    @(negedge CLK);
    #3 RESETN = 0;
    #1;
    check("rst_stall", 64'(STALL), 64'(0));
    check("rst_ack", 64'(ISS_ACK), 64'(0));
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_rdata", 64'(RDATA), 64'(0));
    @(negedge CLK);
    #1 RESETN = 1;
    model_clear();
    idle(3, 7, 2'b11);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int wba;
      logic wbwe;
      wbwe = ($urandom % 3) != 0;
      if (inflight.size() > 0 && ($urandom % 4) != 0)
        wba = inflight[$urandom % inflight.size()];
      else
        wba = $urandom % NREG;
      step(1'($urandom), 1'($urandom), $urandom % NREG, $urandom % NREG, $urandom % NREG,
           2'($urandom), wbwe, wba, 16'($urandom), ($urandom % 64) == 0);
    end
    idle(0, 0, 2'b00);

    repeat (2) @(negedge CLK);
    #3;
    if (exp_q.size() != 0) check("drain", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
